// File: rtl/imem_loader_pkg.sv
// Shared types and sizing helpers for the instruction-memory loader.
// Imported by the loader top and its word assembler.
package imem_loader_pkg;

    localparam int N_DEF          = 32;
    localparam int ADDR_W_DEF     = 6;
    localparam int BYTES_PER_WORD = N_DEF / 8;
    localparam int DEPTH          = 2 ** ADDR_W_DEF;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        CHECK,
        DONE,
        ERR
    } state_t;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    // A lane counter needs at least one bit even for single-byte words.
    function automatic int lane_w(input int bpw);
        return (bpw > 1) ? $clog2(bpw) : 1;
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects little-endian bytes into an N-bit word and strobes when the last lane arrives.
// The completed word is presented combinationally together with the strobe.
module word_assembler
    import imem_loader_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         byte_valid,
    input  logic [7:0]   byte_in,
    output logic [N-1:0] word,
    output logic         word_complete
);

    localparam int BPW = N / 8;
    localparam int LW  = lane_w(BPW);

    logic [LW-1:0] lane;
    logic [N-1:0]  sreg;

    // Bytes enter at the top and shift down, so the first byte lands in [7:0].
    generate
        if (BPW > 1) begin : g_multi
            assign word = {byte_in, sreg[N-1:8]};
        end else begin : g_single
            assign word = byte_in;
        end
    endgenerate

    assign word_complete = byte_valid && (lane == LW'(BPW - 1));

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            lane <= '0;
            sreg <= '0;
        end else if (byte_valid) begin
            sreg <= word;
            lane <= word_complete ? '0 : lane + LW'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the writable instruction memory.
// Writes one word per four data bytes, verifies an XOR checksum and releases cpu_hold on success.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [N-1:0]      wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int DEPTH_L = depth_of(ADDR_W);

    state_t            state, state_nxt;
    logic              accept;
    logic              count_ok;
    logic              frame_start;
    logic              asm_valid;
    logic              word_complete;
    logic [N-1:0]      asm_word;
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W-1:0] last_idx;
    logic [7:0]        csum;

    // No backpressure: the loader takes a byte every cycle it is out of reset.
    assign rx_ready = reset;
    assign accept   = rx_valid && rx_ready;
    assign count_ok = (rx_data != 8'd0) && (32'(rx_data) <= 32'(DEPTH_L));

    word_assembler #(.N(N)) u_asm (
        .clk           (clk),
        .reset         (reset),
        .clear         (frame_start),
        .byte_valid    (asm_valid),
        .byte_in       (rx_data),
        .word          (asm_word),
        .word_complete (word_complete)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: if (accept) state_nxt = count_ok ? DATA : ERR;
            DATA:            if (word_complete && word_idx == last_idx) state_nxt = CHECK;
            CHECK:           if (accept) state_nxt = (rx_data == csum) ? DONE : ERR;
            default:         state_nxt = IDLE;
        endcase
    end

    always_comb begin
        done        = (state == DONE);
        err         = (state == ERR);
        cpu_hold    = (state != DONE);
        frame_start = accept && count_ok &&
                      (state == IDLE || state == DONE || state == ERR);
        asm_valid   = accept && (state == DATA);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            word_idx <= '0;
            last_idx <= '0;
            csum     <= '0;
        end else begin
            we <= word_complete;
            if (frame_start) begin
                word_idx <= '0;
                csum     <= '0;
                last_idx <= ADDR_W'(8'(rx_data - 8'd1));
            end
            if (asm_valid) csum <= csum ^ rx_data;
            // waddr/wdata only move on a write, so they hold between pulses.
            if (word_complete) begin
                waddr    <= word_idx;
                wdata    <= asm_word;
                word_idx <= word_idx + ADDR_W'(1);
            end
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream writer that fills a writable instruction memory: the write-side counterpart of the processor's read-only instruction fetch path.
- Accepts a framed byte stream, assembles 32-bit little-endian instruction words, issues one memory write per word, and verifies a trailing XOR checksum.
- Holds the single-cycle processor in reset (`cpu_hold`) until a load completes cleanly.

Parameters:
- N, 32, instruction word width in bits; must be a multiple of 8.
- ADDR_W, 6, instruction memory address width; DEPTH = 2**ADDR_W = 64 words.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid this cycle.
- rx_ready  out  1  loader accepts a byte this cycle; transfer occurs when rx_valid && rx_ready.
- we  out  1  instruction memory write enable, one-cycle pulse per word.
- waddr  out  ADDR_W  word address of the current write.
- wdata  out  N  word to write.
- cpu_hold  out  1  processor held in reset while 1.
- done  out  1  level: last load succeeded.
- err  out  1  level: last load failed.

Behaviour:
- Frame format: count byte C, then 4*C data bytes (little-endian: byte k of a word → wdata[8k+7:8k]), then checksum byte = XOR of all data bytes. The count byte is excluded from the checksum.
- States: IDLE, DATA, CHECK, DONE, ERR.
- Reset (reset==0 at an edge): state→IDLE. Outputs: we=0, waddr=0, wdata=0, done=0, err=0, cpu_hold=1, lane counter=0, word index=0, checksum accumulator=0. rx_ready=0 in any cycle where reset==0.
- rx_ready: combinational, 1 in every state while reset==1. No backpressure; full throughput is one byte per cycle.
- IDLE, DONE, ERR on accepted byte C:
  - if 1 ≤ C ≤ DEPTH: →DATA; clear word index, lane counter and checksum; done=0, err=0, cpu_hold=1.
  - if C==0 or C>DEPTH: →ERR, err=1, cpu_hold=1, done=0.
- DATA on accepted byte:
  - Shift the byte into the assembly register at the current lane and XOR it into the checksum.
  - On lane 3: next cycle we=1, waddr=word index, wdata=assembled word; word index then increments.
  - Write latency is exactly 1 cycle after the 4th byte's handshake.
  - wdata/waddr hold their values until the next write. The assembly register is separate from wdata, so a byte accepted during the we cycle is not corrupted.
  - After the 4th byte of word C-1: →CHECK.
- CHECK on accepted byte:
  - equal to checksum: →DONE, done=1, cpu_hold=0.
  - otherwise: →ERR, err=1, cpu_hold=1.
- cpu_hold is 0 only in DONE. done and err are never both 1.
- we is never asserted outside the cycle following a lane-3 byte in DATA. Write addresses run strictly 0..C-1, with no wrap: the count check guarantees C ≤ DEPTH.
- Cycles with rx_valid=0: no state change, except the pending we pulse completes.
- Reset mid-load: immediate return to IDLE; a pending we pulse is cancelled. Words already written are not erased.
- A new frame can start from DONE or ERR without a reset.

Decomposition:
- Package imem_loader_pkg holds:
  - state_t enum (IDLE, DATA, CHECK, DONE, ERR);
  - BYTES_PER_WORD = N/8;
  - DEPTH localparam function of ADDR_W.
- One natural sub-module, word_assembler:
  - contents: lane counter, shift register, word_complete strobe;
  - control: clear input driven by the FSM.
- FSM, word index, checksum and output registers live in imem_loader.

Test Plan:
1. Single word, rx_valid continuous: bytes 01, c9, 03, 1f, 8b, 5e → we=1 for one cycle, one cycle after the 8b handshake, with waddr=0, wdata=0x8b1f03c9. After the 5e handshake: done=1, cpu_hold=0, err=0.
2. Two words: 02; c9 03 1f 8b; 02 00 00 f8; checksum a4 → writes addr0=0x8b1f03c9 and addr1=0xf8000002, each 1 cycle after its 4th byte. Then done=1.
3. Bad checksum: frame from test 1 with final byte a5 → err=1, done=0, cpu_hold=1. A following valid frame from test 1 → done=1, err=0.
4. Invalid counts: count byte 00, and separately 41 (65) → err=1 on the next cycle, no we pulse, cpu_hold=1.
5. reset low for one cycle after bytes 01, c9, 03 → state IDLE, no we pulse, cpu_hold=1. A full test-1 frame afterwards succeeds.
6. count=64 (0x40) with random rx_valid gaps → exactly 64 we pulses, addresses 0..63 in order with matching data, done=1 after the correct checksum.
